regfile_port_arbiter: RTL and testbench
=======================================

// Module: regfile_port_arbiter
// PURPOSE
//  Shares the single-port register file between two requesters: the sample loader (write) and the
//  FIR MAC sequencer (dual-operand read). One regfile op per cycle; valid/ready handshakes per side.
//  Holds the read response until it is consumed; a starvation counter bounds read wait under writes.
//  Sits between the loader/MAC and the regfile instance; drives all regfile control pins.
// PARAMETERS
//  DATA_WIDTH      32  sample/coefficient word width
//  REGFILE_ADDR_W  5   regfile address width (2**W entries)
//  STARVE_LIMIT    4   max consecutive cycles an eligible read loses to a write (0 = read always wins)
// PORTS
//  clk          in   1    clock
//  rst          in   1    reset, synchronous, active-low
//  wr_valid     in   1    loader write request
//  wr_ready     out  1    write granted this cycle
//  wr_addr      in   AW   write address
//  wr_data      in   DW   write data
//  rd_valid     in   1    MAC read request
//  rd_ready     out  1    read granted this cycle
//  rd_addr_a    in   AW   operand A address
//  rd_addr_b    in   AW   operand B address
//  rsp_valid    out  1    read response valid
//  rsp_ready    in   1    MAC accepts response
//  rsp_a/rsp_b  out  DW   response operands (pass-through of rf_ra/rf_rb)
//  rf_en        out  1    regfile enable
//  rf_rw        out  1    regfile op: 0 = write, 1 = read
//  rf_a_ra/rf_a_rb/rf_a_rd  out AW  regfile addresses
//  rf_rd        out  DW   regfile write data
//  rf_ra/rf_rb  in   DW   regfile read outputs
// BEHAVIOUR
//  - Reset (rst=0 at posedge): state=S_IDLE, starve_cnt=0. While rst=0: wr_ready=rd_ready=rsp_valid=0,
//    rf_en=0. All regfile address/data outputs are 0 when rf_en=0.
//  - FSM: S_IDLE (no response outstanding), S_RSP (response presented, rsp_valid=1).
//  - rsp_free = (state==S_IDLE) | rsp_ready. starve_hit = (starve_cnt >= STARVE_LIMIT).
//  - rd_grant = rd_valid & rsp_free & (~wr_valid | starve_hit); wr_grant = wr_valid & ~rd_grant.
//  - Grants are combinational, same cycle as valid: rd_ready=rd_grant, wr_ready=wr_grant.
//  - rd_grant: rf_en=1, rf_rw=1, rf_a_ra=rd_addr_a, rf_a_rb=rd_addr_b. wr_grant: rf_en=1, rf_rw=0,
//    rf_a_rd=wr_addr, rf_rd=wr_data. Neither: rf_en=0.
//  - Read latency: grant at cycle N -> rsp_valid=1 from N+1; rsp_a/rsp_b = rf_ra/rf_rb.
//  - Transitions: S_IDLE->S_RSP on rd_grant. S_RSP: rsp_ready&rd_grant -> S_RSP (back-to-back,
//    one read/cycle); rsp_ready&~rd_grant -> S_IDLE; ~rsp_ready -> S_RSP, no new read granted.
//  - Writes are granted while a response is pending; rf_ra/rf_rb are unchanged by writes, so the
//    held response stays stable until rsp_ready.
//  - starve_cnt: +1 when rd_valid & rsp_free & wr_grant; cleared on rd_grant or ~rd_valid.
//    Saturates at STARVE_LIMIT.
//  - No ordering between requesters: a read and a write to the same address in different cycles
//    see regfile order; the same cycle cannot occur (one op per cycle).
//  - Request inputs must stay stable while valid & ~ready; not checked.
//  - rst low mid-read drops the outstanding response (rsp_valid=0 next cycle); no replay.
// STRUCTURE
//  - Shared package srcv_pkg: DATA_WIDTH, REGFILE_ADDR_W defaults, arbiter state enum
//    (S_IDLE=1'b0, S_RSP=1'b1), RF_OP_WRITE=1'b0 / RF_OP_READ=1'b1.
//  - One sub-module: rf_starve_ctr (saturating counter, inc/clr, hit output).
//  - Rest is grant logic, 1-bit FSM, output muxing.
// TESTING
//  1 Reset: hold rst=0 5 cycles with wr_valid=rd_valid=1 -> rf_en=0, all ready=0, rsp_valid=0.
//  2 Lone read: rd_valid, a=3,b=7 (regfile[3]=0x11,[7]=0x22) -> rd_ready same cycle, rsp next
//    cycle 0x11/0x22.
//  3 Contention, STARVE_LIMIT=4: both valid continuously -> 4 write grants, then read grant on
//    5th cycle, counter clears.
//  4 Backpressure: rsp_ready=0 for 6 cycles, rd_valid=1, wr_valid pulses -> writes granted,
//    rd_ready=0, rsp_a/rsp_b stable.
//  5 Back-to-back reads, rsp_ready=1: 8 reads -> 8 consecutive rd_ready, rsp_valid continuous.
//  6 rst=0 while S_RSP -> rsp_valid=0 next cycle; after release, first read behaves as in test 2.

Source files
------------

// File: rtl/srcv_pkg.sv
// Shared definitions for the sample/coefficient regfile slice:
// default widths, arbiter state encoding and regfile op codes.
package srcv_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REGFILE_ADDR_W = 5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RSP  = 1'b1
  } arb_state_e;

  localparam logic RF_OP_WRITE = 1'b0;
  localparam logic RF_OP_READ  = 1'b1;

endpackage

// File: rtl/rf_starve_ctr.sv
// Saturating count of consecutive cycles an eligible read lost to a write.
// A limit of zero makes the hit output permanently true, so reads always win.
module rf_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_hit
);

  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  assign o_hit = (r_cnt >= CW'(LIMIT));

  // Clear wins over increment; once the limit is reached the count holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_hit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the single-port regfile between the sample loader (writes) and the
// FIR MAC sequencer (dual-operand reads), one regfile op per cycle.
module regfile_port_arbiter
  import srcv_pkg::*;
#(
  parameter int DATA_WIDTH     = srcv_pkg::DATA_WIDTH,
  parameter int REGFILE_ADDR_W = srcv_pkg::REGFILE_ADDR_W,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_wr_valid,
  output logic                      o_wr_ready,
  input  logic [REGFILE_ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0]     i_wr_data,
  input  logic                      i_rd_valid,
  output logic                      o_rd_ready,
  input  logic [REGFILE_ADDR_W-1:0] i_rd_addr_a,
  input  logic [REGFILE_ADDR_W-1:0] i_rd_addr_b,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [DATA_WIDTH-1:0]     o_rsp_a,
  output logic [DATA_WIDTH-1:0]     o_rsp_b,
  output logic                      o_rf_en,
  output logic                      o_rf_rw,
  output logic [REGFILE_ADDR_W-1:0] o_rf_a_ra,
  output logic [REGFILE_ADDR_W-1:0] o_rf_a_rb,
  output logic [REGFILE_ADDR_W-1:0] o_rf_a_rd,
  output logic [DATA_WIDTH-1:0]     o_rf_rd,
  input  logic [DATA_WIDTH-1:0]     i_rf_ra,
  input  logic [DATA_WIDTH-1:0]     i_rf_rb
);

  arb_state_e r_state;
  arb_state_e w_nextState;
  logic       w_rspFree;
  logic       w_starveHit;
  logic       w_rdGrant;
  logic       w_wrGrant;

  // A new read may issue only if the response slot is empty or drains this cycle.
  assign w_rspFree = (r_state == S_IDLE) || i_rsp_ready;
  assign w_rdGrant = rst && i_rd_valid && w_rspFree && (!i_wr_valid || w_starveHit);
  assign w_wrGrant = rst && i_wr_valid && !w_rdGrant;

  assign o_rd_ready  = w_rdGrant;
  assign o_wr_ready  = w_wrGrant;
  assign o_rsp_valid = rst && (r_state == S_RSP);
  assign o_rsp_a     = i_rf_ra;
  assign o_rsp_b     = i_rf_rb;

  rf_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .i_inc (i_rd_valid && w_rspFree && w_wrGrant),
    .i_clr (w_rdGrant || !i_rd_valid),
    .o_hit (w_starveHit)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The response slot refills on any read grant and empties only when consumed without a refill.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (w_rdGrant) w_nextState = S_RSP;
      S_RSP:  if (i_rsp_ready && !w_rdGrant) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    o_rf_en   = 1'b0;
    o_rf_rw   = RF_OP_WRITE;
    o_rf_a_ra = '0;
    o_rf_a_rb = '0;
    o_rf_a_rd = '0;
    o_rf_rd   = '0;
    if (w_rdGrant) begin
      o_rf_en   = 1'b1;
      o_rf_rw   = RF_OP_READ;
      o_rf_a_ra = i_rd_addr_a;
      o_rf_a_rb = i_rd_addr_b;
    end else if (w_wrGrant) begin
      o_rf_en   = 1'b1;
      o_rf_rw   = RF_OP_WRITE;
      o_rf_a_rd = i_wr_addr;
      o_rf_rd   = i_wr_data;
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter: a behavioural regfile sits
// behind the arbiter and a transaction-level model predicts grants and responses.
module tb_regfile_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int STARVE_LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wrValid, rdValid, rspReady;
  logic [AW-1:0] wrAddr, rdAddrA, rdAddrB;
  logic [DW-1:0] wrData;
  logic          wrReady, rdReady, rspValid, rfEn, rfRw;
  logic [DW-1:0] rspA, rspB, rfRd, rfRa, rfRb;
  logic [AW-1:0] rfARa, rfARb, rfARd;

  regfile_port_arbiter #(
    .DATA_WIDTH     (DW),
    .REGFILE_ADDR_W (AW),
    .STARVE_LIMIT   (STARVE_LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_wr_valid  (wrValid),
    .o_wr_ready  (wrReady),
    .i_wr_addr   (wrAddr),
    .i_wr_data   (wrData),
    .i_rd_valid  (rdValid),
    .o_rd_ready  (rdReady),
    .i_rd_addr_a (rdAddrA),
    .i_rd_addr_b (rdAddrB),
    .o_rsp_valid (rspValid),
    .i_rsp_ready (rspReady),
    .o_rsp_a     (rspA),
    .o_rsp_b     (rspB),
    .o_rf_en     (rfEn),
    .o_rf_rw     (rfRw),
    .o_rf_a_ra   (rfARa),
    .o_rf_a_rb   (rfARb),
    .o_rf_a_rd   (rfARd),
    .o_rf_rd     (rfRd),
    .i_rf_ra     (rfRa),
    .i_rf_rb     (rfRb)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] initWord(input int i);
    if (i == 3) return 32'h11;
    if (i == 7) return 32'h22;
    return 32'hA500_0000 ^ (i * 32'h0101_0101);
  endfunction

  // Regfile stand-in: registered read ports, held unless a read is issued.
  logic [DW-1:0] rfMem [32];
  bit            envLoaded = 1'b0;
  always @(posedge clk) begin
    if (!envLoaded) begin
      for (int i = 0; i < 32; i++) rfMem[i] <= initWord(i);
      envLoaded <= 1'b1;
    end else if (rfEn) begin
      if (rfRw) begin
        rfRa <= rfMem[rfARa];
        rfRb <= rfMem[rfARb];
      end else begin
        rfMem[rfARd] <= rfRd;
      end
    end
  end

  // Reference model state: memory image, outstanding response, lost-read streak.
  logic [DW-1:0] refMem [32];
  bit            pend;
  int            losses;
  logic [DW-1:0] expA, expB;
  logic          expRd, expWr, expRspValid, expRfEn;
  int            nCompared = 0;
  int            nMismatched = 0;

  task automatic evalModel();
    bit free;
    free = !pend || rspReady;
    expRd = 1'b0;
    expWr = 1'b0;
    if (rst) begin
      expRd = rdValid && free && (!wrValid || losses >= STARVE_LIMIT);
      expWr = wrValid && !expRd;
    end
    expRspValid = rst && pend;
    expRfEn = expRd || expWr;
  endtask

  task automatic advance();
    bit free;
    free = !pend || rspReady;
    @(posedge clk);
    if (!rst) begin
      pend = 0;
      losses = 0;
    end else begin
      if (expRd || !rdValid) losses = 0;
      else if (free && expWr) losses = (losses + 1 > STARVE_LIMIT) ? STARVE_LIMIT : losses + 1;
      if (expWr) refMem[wrAddr] = wrData;
      if (expRd) begin
        pend = 1;
        expA = refMem[rdAddrA];
        expB = refMem[rdAddrB];
      end else if (pend && rspReady) begin
        pend = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic applyIdle();
    wrValid = 0; rdValid = 0; rspReady = 1;
    wrAddr = 0; wrData = 0; rdAddrA = 0; rdAddrB = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      wrValid = 1; rdValid = 1; rspReady = $urandom_range(0, 1);
      wrAddr = AW'($urandom); wrData = $urandom; rdAddrA = AW'($urandom); rdAddrB = AW'($urandom);
      #1; evalModel();
      nCompared++;
      if ({rdReady, wrReady, rspValid, rfEn} !== 4'b0000) begin
        nMismatched++;
        $display("[TB] FAIL reset_ctl got %b want 0000", {rdReady, wrReady, rspValid, rfEn});
      end
      nCompared++;
      if ({rfARa, rfARb, rfARd, rfRd} !== '0) begin
        nMismatched++;
        $display("[TB] FAIL reset_rfbus got %h want 0", {rfARa, rfARb, rfARd, rfRd});
      end
      advance();
    end
    rst = 1;
    applyIdle();
  endtask

  task automatic test_lone_read(input string tag);
    applyIdle();
    rdValid = 1; rdAddrA = 3; rdAddrB = 7;
    #1; evalModel();
    nCompared++;
    if ({rdReady, wrReady, rfEn, rfRw, rfARa, rfARb} !== {4'b1011, 5'd3, 5'd7}) begin
      nMismatched++;
      $display("[TB] FAIL %s_grant got %b/%0d/%0d want 1011/3/7", tag,
               {rdReady, wrReady, rfEn, rfRw}, rfARa, rfARb);
    end
    advance();
    applyIdle();
    #1; evalModel();
    nCompared++;
    if ({rspValid, rspA, rspB} !== {1'b1, 32'h11, 32'h22}) begin
      nMismatched++;
      $display("[TB] FAIL %s_rsp got %b %h %h want 1 00000011 00000022", tag, rspValid, rspA, rspB);
    end
    advance();
    #1; evalModel();
    nCompared++;
    if (rspValid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL %s_drain got %b want 0", tag, rspValid);
    end
  endtask

  task automatic test_contention();
    applyIdle();
    #1; evalModel(); advance();
    for (int i = 0; i < 6; i++) begin
      wrValid = 1; rdValid = 1; rspReady = 1;
      wrAddr = AW'(8 + $urandom_range(0, 23)); wrData = $urandom;
      rdAddrA = AW'($urandom); rdAddrB = AW'($urandom);
      #1; evalModel();
      nCompared++;
      if ({rdReady, wrReady} !== ((i == 4) ? 2'b10 : 2'b01)) begin
        nMismatched++;
        $display("[TB] FAIL contention_cycle%0d got %b want %b", i, {rdReady, wrReady},
                 (i == 4) ? 2'b10 : 2'b01);
      end
      nCompared++;
      if ({rdReady, wrReady, rspValid, rfEn} !== {expRd, expWr, expRspValid, expRfEn} ||
          (expWr && {rfRw, rfARd, rfRd} !== {1'b0, wrAddr, wrData}) ||
          (expRspValid && {rspA, rspB} !== {expA, expB})) begin
        nMismatched++;
        $display("[TB] FAIL contention_model%0d got %b %h want %b %h", i,
                 {rdReady, wrReady, rspValid, rfEn}, {rfARd, rfRd}, {expRd, expWr, expRspValid, expRfEn},
                 {wrAddr, wrData});
      end
      advance();
    end
    applyIdle();
    #1; evalModel(); advance();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] heldA, heldB;
    applyIdle();
    rdValid = 1; rdAddrA = AW'($urandom); rdAddrB = AW'($urandom);
    #1; evalModel(); advance();
    heldA = expA; heldB = expB;
    for (int i = 0; i < 6; i++) begin
      rspReady = 0; rdValid = 1; rdAddrA = AW'($urandom); rdAddrB = AW'($urandom);
      wrValid = (i % 2 == 0); wrAddr = AW'(8 + $urandom_range(0, 23)); wrData = $urandom;
      #1; evalModel();
      nCompared++;
      if ({rdReady, wrReady, rspValid} !== {1'b0, wrValid, 1'b1}) begin
        nMismatched++;
        $display("[TB] FAIL backpressure_hs%0d got %b want 0%b1", i, {rdReady, wrReady, rspValid}, wrValid);
      end
      nCompared++;
      if ({rspA, rspB} !== {heldA, heldB}) begin
        nMismatched++;
        $display("[TB] FAIL backpressure_hold%0d got %h %h want %h %h", i, rspA, rspB, heldA, heldB);
      end
      advance();
    end
    rspReady = 1; wrValid = 0;
    #1; evalModel();
    nCompared++;
    if ({rdReady, rspValid} !== 2'b11) begin
      nMismatched++;
      $display("[TB] FAIL backpressure_release got %b want 11", {rdReady, rspValid});
    end
    advance();
    applyIdle();
    #1; evalModel(); advance();
  endtask

  task automatic test_back_to_back();
    int granted;
    granted = 0;
    for (int i = 0; i < 9; i++) begin
      applyIdle();
      rdValid = (i < 8); rdAddrA = AW'($urandom); rdAddrB = AW'($urandom);
      #1; evalModel();
      if (rdReady === 1'b1) granted++;
      nCompared++;
      if (rspValid !== (i > 0) || (i > 0 && {rspA, rspB} !== {expA, expB})) begin
        nMismatched++;
        $display("[TB] FAIL b2b_rsp%0d got %b %h %h want %b %h %h", i, rspValid, rspA, rspB,
                 (i > 0), expA, expB);
      end
      advance();
    end
    nCompared++;
    if (granted != 8) begin
      nMismatched++;
      $display("[TB] FAIL b2b_grants got %0d want 8", granted);
    end
  endtask

  task automatic test_reset_mid_read();
    applyIdle();
    rdValid = 1; rdAddrA = 9; rdAddrB = 10;
    #1; evalModel(); advance();
    applyIdle();
    rspReady = 0; rst = 0;
    #1; evalModel(); advance();
    rst = 1;
    #1; evalModel();
    nCompared++;
    if (rspValid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL midreset_drop got %b want 0", rspValid);
    end
    test_lone_read("midreset_read");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wrValid = $urandom_range(0, 1); rdValid = ($urandom_range(0, 3) != 0);
      rspReady = ($urandom_range(0, 2) != 0);
      wrAddr = AW'($urandom); wrData = $urandom; rdAddrA = AW'($urandom); rdAddrB = AW'($urandom);
      #1; evalModel();
      nCompared++;
      if ({rdReady, wrReady, rspValid, rfEn} !== {expRd, expWr, expRspValid, expRfEn} ||
          (expRspValid && {rspA, rspB} !== {expA, expB})) begin
        nMismatched++;
        $display("[TB] FAIL random%0d got %b %h %h want %b %h %h", i, {rdReady, wrReady, rspValid, rfEn},
                 rspA, rspB, {expRd, expWr, expRspValid, expRfEn}, expA, expB);
      end
      advance();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) refMem[i] = initWord(i);
    pend = 0; losses = 0; expA = '0; expB = '0;
    rst = 0;
    applyIdle();
    @(negedge clk);
    test_reset();
    test_lone_read("lone_read");
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
